systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Output stage directly downstream of the systolic matrix-multiply array.
- Waits a fixed number of cycles after a matmul starts, then snapshots the AROW x BCOL grid of 2N-bit accumulators.
- Requantizes each element to N bits: arithmetic shift, optional ReLU, then saturation.
- Streams the results row-major over a valid/ready interface to the next layer or a result buffer.

Parameters:
- N, 16: output element width; input accumulators are 2N bits wide.
- AROW, 3: rows of the result grid.
- BCOL, 3: columns of the result grid.
- WAIT_CYCLES, 8: cycles from start until the array outputs are stable. Must be >= 1.
- FRAC, 8: arithmetic right-shift amount used for requantization. Range 0..2N-1.
- RELU, 1: 1 clamps negative results to 0; 0 passes them through.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse, asserted together with the array's valid.
- sys_array  in  AROW*BCOL*2N  accumulator grid. Element (r,c) is at bits [(r*BCOL+c)*2N +: 2N], signed two's complement.
- out_data  out  N  requantized element, signed.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the element.
- out_row  out  $clog2(AROW) (min 1)  row index of out_data.
- out_col  out  $clog2(BCOL) (min 1)  column index of out_data.
- out_last  out  1  high with the final element (AROW-1, BCOL-1).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE. All outputs are 0: out_data, out_valid, out_row, out_col, out_last, busy, done. Wait counter and snapshot register are cleared.
- A reset asserted in any state, including mid-stream, aborts the operation on that edge. No done pulse is produced.
- FSM states are IDLE, WAIT, CAPTURE, STREAM.
- IDLE:
  - start=1 -> WAIT, with cnt=WAIT_CYCLES-1.
  - Otherwise stay in IDLE.
- WAIT:
  - cnt!=0 -> decrement cnt.
  - cnt==0 -> CAPTURE.
- CAPTURE (one cycle):
  - Register all AROW*BCOL requantized elements into the snapshot.
  - Set row=0, col=0.
  - -> STREAM, with out_valid=1.
- Timing: if start is sampled at edge E0, out_valid is first high after edge E0+WAIT_CYCLES+1.
- STREAM:
  - out_data, out_row, out_col and out_last come from the snapshot via registered outputs.
  - A handshake is out_valid & out_ready at an edge.
  - On a handshake, advance col; when col wraps to 0, advance row.
  - The next element is presented in the following cycle. With out_ready held high there are no bubbles: one element per cycle.
  - Without a handshake, all out_* signals hold stable.
  - When the handshake carries out_last: -> IDLE, out_valid=0, and done=1 for exactly the next cycle.
- start while busy=1 is ignored. It is neither queued nor does it restart the operation.
- start in the same cycle done is high is accepted, since the FSM is in IDLE.
- sys_array is sampled only in CAPTURE. Changes afterwards do not affect the stream.
- Requantization per element x (signed 2N bits):
  - s = x >>> FRAC (arithmetic shift, truncation toward -inf).
  - If RELU=1 and s<0, then s=0.
  - If s > 2^(N-1)-1, output 0x7FF..F.
  - Else if s < -2^(N-1), output 0x80..0.
  - Else output s[N-1:0].
- out_row and out_col reset to 0 and return to 0 after the final element.

Test Plan:
Configuration for all scenarios: N=16, AROW=BCOL=3, WAIT_CYCLES=8, FRAC=8, RELU=1 unless stated.
1. Reset: hold rst 2 cycles with start=1 and random sys_array -> all outputs 0, busy=0. Releasing rst with start=0 keeps the block in IDLE.
2. Basic stream: every element = 0x00000300, start at E0, out_ready=1 ->
   - out_valid first high after E0+9.
   - 9 consecutive elements of 0x0003, with (row,col) going (0,0),(0,1)..(2,2).
   - out_last only on (2,2).
   - done pulses one cycle after it; busy falls with done.
3. Arithmetic, per element:
   - 0x7FFFFFFF -> 0x7FFF.
   - 0xFFFFFE00 -> 0x0000 with RELU=1; 0xFFFE with RELU=0.
   - 0x80000000 with RELU=0 -> 0x8000.
   - 0x000001FF -> 0x0001.
   - 0xFFFFFFFF with RELU=0 -> 0xFFFF.
4. Backpressure: out_ready pattern 1,0,0,1,0,1... -> out_data/row/col/last stable while out_valid&!out_ready. Exactly 9 handshakes in order; no element dropped or duplicated.
5. Snapshot and start ignore: change sys_array to 0x0000AB00 after CAPTURE and pulse start mid-STREAM -> the stream still carries the original values. No second operation follows done.
6. Mid-stream reset: assert rst after the 4th handshake -> next cycle out_valid=0, busy=0, done=0. A new start then produces a full 9-element stream from (0,0).

Source files
------------

// File: rtl/systolic_drain.sv
// Output stage for the systolic matmul array: waits for the array to settle, snapshots the
// accumulator grid requantized to N bits, then streams it row-major over valid/ready.
module systolic_drain #(
    parameter int N           = 16,
    parameter int AROW        = 3,
    parameter int BCOL        = 3,
    parameter int WAIT_CYCLES = 8,
    parameter int FRAC        = 8,
    parameter int RELU        = 1,
    localparam int NE   = AROW * BCOL,
    localparam int RW   = (AROW > 1) ? $clog2(AROW) : 1,
    localparam int CW   = (BCOL > 1) ? $clog2(BCOL) : 1,
    localparam int IW   = (NE > 1) ? $clog2(NE) : 1,
    localparam int CNTW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NE*2*N-1:0]   sys_array,
    output logic [N-1:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RW-1:0]       out_row,
    output logic [CW-1:0]       out_col,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        STREAM  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [N-1:0]    snap_q [NE];
    logic [N-1:0]    quant  [NE];
    logic [IW-1:0]   idx_q, idx_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            last_d;
    logic [N-1:0]    out_data_q;
    logic            out_valid_q, out_last_q, busy_q, done_q;

    // Shift, optional ReLU, then saturate to the signed N-bit range.
    function automatic logic [N-1:0] requant(input logic [2*N-1:0] x);
        logic signed [2*N-1:0] s;
        s = $signed(x) >>> FRAC;
        if (RELU != 0 && s[2*N-1]) s = '0;
        if (s[2*N-1:N-1] == {(N+1){s[2*N-1]}}) return s[N-1:0];
        else if (s[2*N-1])                      return {1'b1, {(N-1){1'b0}}};
        else                                    return {1'b0, {(N-1){1'b1}}};
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        quant = '{default: '0};
        for (int i = 0; i < NE; i++) quant[i] = requant(sys_array[i*2*N +: 2*N]);
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (col_q == CW'(BCOL - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end else begin
            col_d = col_q + 1'b1;
        end
        idx_d  = idx_q + 1'b1;
        last_d = (row_d == RW'(AROW - 1)) && (col_d == CW'(BCOL - 1));
    end

    // NOTE: the snapshot is small enough to reset explicitly, so it never leaks a stale grid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NE; i++) snap_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WAIT;
                        cnt_q   <= CNTW'(WAIT_CYCLES - 1);
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else             state_q <= CAPTURE;
                end
                CAPTURE: begin
                    snap_q      <= quant;
                    out_data_q  <= quant[0];
                    idx_q       <= '0;
                    row_q       <= '0;
                    col_q       <= '0;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (NE == 1);
                    state_q     <= STREAM;
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            idx_q       <= '0;
                            row_q       <= '0;
                            col_q       <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            idx_q      <= idx_d;
                            row_q      <= row_d;
                            col_q      <= col_d;
                            out_data_q <= snap_q[idx_d];
                            out_last_q <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: table vectors, hand-built corner sequences and
// randomized grids checked against a plain-arithmetic requantization model (ReLU on and off).
module tb_systolic_drain;

    localparam int N  = 16;
    localparam int NE = 9;

    logic              clk = 1'b0;
    logic              rst, start, out_ready;
    logic [NE*32-1:0]  sys_array;
    logic [31:0]       grid [NE];

    logic [15:0] out_data,  nr_data;
    logic        out_valid, nr_valid, out_last, nr_last;
    logic [1:0]  out_row, nr_row, out_col, nr_col;
    logic        busy, nr_busy, done, nr_done;

    systolic_drain #(.N(N), .AROW(3), .BCOL(3), .WAIT_CYCLES(8), .FRAC(8), .RELU(1)) dut (
        .clk(clk), .rst(rst), .start(start), .sys_array(sys_array),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .done(done));

    systolic_drain #(.N(N), .AROW(3), .BCOL(3), .WAIT_CYCLES(8), .FRAC(8), .RELU(0)) dut_nr (
        .clk(clk), .rst(rst), .start(start), .sys_array(sys_array),
        .out_data(nr_data), .out_valid(nr_valid), .out_ready(out_ready),
        .out_row(nr_row), .out_col(nr_col), .out_last(nr_last),
        .busy(nr_busy), .done(nr_done));

    always #5 clk = ~clk;

    always_comb begin
        sys_array = '0;
        for (int i = 0; i < NE; i++) sys_array[i*32 +: 32] = grid[i];
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_r [NE];
    logic [15:0] exp_n [NE];

    typedef struct {
        logic [31:0] x;
        logic [15:0] exp_relu;
        logic [15:0] exp_norelu;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // floor(x / 2^8), optional ReLU, clamp into [-32768, 32767].
    function automatic logic [15:0] ref_q(input logic [31:0] x, input bit relu);
        longint v, q;
        v = longint'($signed(x));
        q = v / 256;
        if ((v % 256) != 0 && v < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic load_random_grid();
        for (int i = 0; i < NE; i++) begin
            case ($urandom_range(0, 3))
                0: grid[i] = $urandom;
                1: grid[i] = 32'($signed($urandom_range(0, 20000)) - 10000);
                2: grid[i] = 32'h007F_FF00 + 32'($urandom_range(0, 511)) - 32'd256;
                default: grid[i] = 32'hFF80_0000 + 32'($urandom_range(0, 511)) - 32'd256;
            endcase
        end
    endtask

    task automatic set_model();
        for (int i = 0; i < NE; i++) begin
            exp_r[i] = ref_q(grid[i], 1'b1);
            exp_n[i] = ref_q(grid[i], 1'b0);
        end
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1,0,1, 2: random.
    task automatic run_stream(input int mode, input bit disturb, input int abort_after);
        int  lat, k, cyc;
        bit  rdy, disturbed;
        bit  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("first_valid_latency", lat, 32'd10);
        k = 0;
        cyc = 0;
        disturbed = 1'b0;
        while (k < NE && cyc < 300) begin
            check("valid", {31'b0, out_valid}, 32'd1);
            check("data_relu", out_data, exp_r[k]);
            check("data_norelu", nr_data, exp_n[k]);
            check("row", out_row, k / 3);
            check("col", out_col, k % 3);
            check("last", {31'b0, out_last}, {31'b0, k == NE - 1});
            check("done_low_in_stream", {31'b0, done}, 32'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = 1'b0;
            if (disturb && !disturbed && k == 2) begin
                for (int i = 0; i < NE; i++) grid[i] = 32'h0000_AB00;
                start = 1'b1;
                disturbed = 1'b1;
            end
            if (rdy) k++;
            @(negedge clk);
            cyc++;
            if (abort_after > 0 && k == abort_after) begin
                out_ready = 1'b0;
                start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                check("abort_valid", {31'b0, out_valid}, 32'd0);
                check("abort_busy", {31'b0, busy}, 32'd0);
                check("abort_done", {31'b0, done}, 32'd0);
                check("abort_rowcol", {out_row, out_col}, 32'd0);
                rst = 1'b0;
                @(negedge clk);
                check("abort_no_done_after", {31'b0, done}, 32'd0);
                return;
            end
        end
        start = 1'b0;
        if (cyc >= 300) check("stream_budget", cyc, 32'd0);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("done_norelu", {31'b0, nr_done}, 32'd1);
        check("busy_falls", {31'b0, busy}, 32'd0);
        check("valid_falls", {31'b0, out_valid}, 32'd0);
        check("rowcol_return", {out_row, out_col, out_last}, 32'd0);
        if (mode == 0) check("no_bubbles", cyc, NE);
        out_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        vec_t vecs [NE];
        bit   saw_activity;

        vecs[0] = '{32'h7FFF_FFFF, 16'h7FFF, 16'h7FFF};
        vecs[1] = '{32'hFFFF_FE00, 16'h0000, 16'hFFFE};
        vecs[2] = '{32'h8000_0000, 16'h0000, 16'h8000};
        vecs[3] = '{32'h0000_01FF, 16'h0001, 16'h0001};
        vecs[4] = '{32'hFFFF_FFFF, 16'h0000, 16'hFFFF};
        vecs[5] = '{32'h0080_0000, 16'h7FFF, 16'h7FFF};
        vecs[6] = '{32'h007F_FF00, 16'h7FFF, 16'h7FFF};
        vecs[7] = '{32'hFF80_0000, 16'h0000, 16'h8000};
        vecs[8] = '{32'hFF7F_FF00, 16'h0000, 16'h8000};

        // Reset held two cycles with start asserted.
        rst = 1'b1;
        start = 1'b1;
        out_ready = 1'b0;
        load_random_grid();
        repeat (2) @(negedge clk);
        check("rst_data", out_data, 32'd0);
        check("rst_flags", {out_valid, out_last, busy, done}, 32'd0);
        check("rst_rowcol", {out_row, out_col}, 32'd0);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {out_valid, busy, done}, 32'd0);

        // Basic stream of constant 0x300 elements.
        for (int i = 0; i < NE; i++) begin
            grid[i]  = 32'h0000_0300;
            exp_r[i] = 16'h0003;
            exp_n[i] = 16'h0003;
        end
        run_stream(0, 1'b0, 0);

        // Arithmetic table.
        for (int i = 0; i < NE; i++) begin
            grid[i]  = vecs[i].x;
            exp_r[i] = vecs[i].exp_relu;
            exp_n[i] = vecs[i].exp_norelu;
        end
        run_stream(0, 1'b0, 0);

        // Backpressure pattern.
        load_random_grid();
        set_model();
        run_stream(1, 1'b0, 0);

        // Snapshot held and mid-stream start ignored.
        load_random_grid();
        set_model();
        run_stream(1, 1'b1, 0);
        saw_activity = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) saw_activity = 1'b1;
        end
        check("no_second_op", {31'b0, saw_activity}, 32'd0);

        // Mid-stream reset, then a full fresh stream.
        load_random_grid();
        set_model();
        run_stream(0, 1'b0, 4);
        load_random_grid();
        set_model();
        run_stream(0, 1'b0, 0);

        // Randomized grids with random backpressure.
        for (int t = 0; t < 6; t++) begin
            load_random_grid();
            set_model();
            run_stream(2, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
